// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one load/store, waits LATENCY cycles,
// performs the access on a 2^DEPTH_LOG2 x 64-bit array and holds the response until taken.
module mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  input  logic        req_wen_i,
  input  logic [1:0]  req_size_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem_q [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic [2:0]  off;
  logic [2:0]  size_m1;
  logic [7:0]  size_be, byte_en;
  logic [63:0] size_mask, wmask, wdata_sh, rd_word, ld_data;
  logic        acc_err, do_access;

  always_comb begin
    word_idx = addr_q[DEPTH_LOG2+2:3];
    off      = addr_q[2:0];
    size_m1  = 3'((4'd1 << size_q) - 4'd1);
    size_be  = 8'((9'd1 << (4'd1 << size_q)) - 9'd1);
    byte_en  = size_be << off;
    for (int b = 0; b < 8; b++) begin
      size_mask[8*b +: 8] = {8{size_be[b]}};
      wmask[8*b +: 8]     = {8{byte_en[b]}};
    end
    wdata_sh  = wdata_q << {off, 3'b000};
    rd_word   = mem_q[word_idx];
    ld_data   = (rd_word >> {off, 3'b000}) & size_mask;
    acc_err   = (|(off & size_m1)) | (|addr_q[63:DEPTH_LOG2+3]);
    do_access = (state_q == WAIT) && (cnt_q == 4'd0);
  end

  // Write is gated by reset so an aborted store never lands.
  always_ff @(posedge clock_i) begin
    if (!reset_i && do_access && wen_q && !acc_err)
      mem_q[word_idx] <= (rd_word & ~wmask) | (wdata_sh & wmask);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (req_valid_i) begin
        addr_d  = req_addr_i;
        wen_d   = req_wen_i;
        size_d  = req_size_i;
        wdata_d = req_wdata_i;
        cnt_d   = 4'(LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == 4'd0) begin
        err_d   = acc_err;
        rdata_d = (acc_err || wen_q) ? 64'd0 : ld_data;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 64'd0;
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8: memory holds 2^DEPTH_LOG2 64-bit words.
REQ-002 Parameter LATENCY, default 2, legal range 1..15: cycles from request accept to resp_valid.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_addr  input  64  byte address.
REQ-008 req_wen  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  access size: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-010 req_wdata  input  64  store data, right-aligned (byte 0 = lowest bits).
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator takes the response.
REQ-013 resp_rdata  output  64  load data, right-aligned, zero-extended.
REQ-014 resp_err  output  1  request faulted; no memory side effect.

Function
REQ-015 FSM states are IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE, and resp_valid SHALL be 1 only in RESP.
REQ-016 Handshake: accept when req_valid && req_ready; addr, wen, size and wdata latched on accept; FSM moves IDLE->WAIT with counter = LATENCY-1.
REQ-017 WAIT: counter decrements each cycle; on the cycle counter==0, perform the access and move to RESP; resp_valid SHALL rise exactly LATENCY cycles after the accept edge.
REQ-018 RESP: resp_rdata and resp_err held stable until resp_valid && resp_ready; then RESP->IDLE, with req_ready high the next cycle (no request accepted in the same cycle as the response handshake).
REQ-019 Word index = addr[DEPTH_LOG2+2:3]; byte offset = addr[2:0]; byte count = 1<<size.
REQ-020 Error: offset not a multiple of the byte count (misaligned) or addr[63:DEPTH_LOG2+3] nonzero (out of range) SHALL give resp_err=1, resp_rdata=0, no write.
REQ-021 Store: byte mask = ((1<<count)-1)<<offset; only masked bytes of the word updated with wdata<<(8*offset); unmasked bytes unchanged; resp_rdata=0, resp_err=0.
REQ-022 Load: resp_rdata = (word>>(8*offset)) with bits above 8*count cleared; resp_err=0.
REQ-023 A load issued after a store to the same address SHALL return the stored data (store commits before RESP entry).
REQ-024 resp_ready asserted outside RESP and req_valid asserted outside IDLE SHALL be ignored.
REQ-025 Memory array is not reset; contents are undefined until written.

Reset
REQ-026 reset SHALL force state IDLE, counter 0, req_ready=1 on the following cycle, and resp_valid=0, resp_rdata=0, resp_err=0.
REQ-027 reset asserted in WAIT SHALL abort the request, with no memory write; reset asserted in RESP SHALL drop the pending response.
REQ-028 reset has priority over every handshake in the same cycle.

Verification
REQ-029 Store addr 0x10, size 3, wdata 0x1122334455667788; then load addr 0x10, size 3 -> rdata 0x1122334455667788, err 0, each resp_valid rising 2 cycles after accept.
REQ-030 After REQ-029, store addr 0x13, size 0, wdata 0xAB; load 0x10 size 3 -> 0x11223344AB667788; load 0x12 size 1 -> 0xAB66.
REQ-031 Load addr 0x11, size 2 (misaligned) -> err 1, rdata 0; load addr 0x800 (out of range at DEPTH_LOG2=8) -> err 1; the memory word at 0x10 is unchanged.
REQ-032 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and rdata stay stable and req_ready stays 0; assert resp_ready -> req_ready=1 the next cycle.
REQ-033 Accept a store to 0x20, assert reset during WAIT -> IDLE next cycle, resp_valid never rises, and a later load of 0x20 returns the pre-store value.
REQ-034 Back-to-back requests with resp_ready tied high and LATENCY=1 -> one transaction per 3 cycles, responses returned in order.
